// File: rtl/pll_lock_ctrl.sv
// PLL lock sequencer: pulses the PLL reset, waits for a synchronized lock that
// stays stable, then releases downstream reset. Retries on timeout and counts lock losses.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RST_PLL  | PLL held in reset for RST_CYCLES cycles
// ST_WAIT_LOCK| PLL released, waiting up to LOCK_TIMEOUT cycles for lock
// ST_STABLE   | lock seen, counting STABLE_CYCLES consecutive lock cycles
// ST_RUN      | locked and stable, downstream released
// ST_FAIL     | retries exhausted, held until restart or reset
module pll_lock_ctrl #(
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_RST_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t        state, state_nxt;
  logic          lock_m, lock_s;
  logic [RW-1:0] rst_cnt, rst_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic [SW-1:0] stb_cnt, stb_cnt_nxt;
  logic [3:0]    retry_nxt;
  logic [7:0]    lost_nxt;

  // lock is asynchronous to clkin
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    to_cnt_nxt  = to_cnt;
    stb_cnt_nxt = stb_cnt;
    retry_nxt   = retry_cnt;
    lost_nxt    = lost_cnt;
    if (restart) begin
      state_nxt   = ST_RST_PLL;
      rst_cnt_nxt = '0;
      retry_nxt   = '0;
    end else begin
      case (state)
        ST_RST_PLL: begin
          if (rst_cnt == RST_LAST) begin
            state_nxt  = ST_WAIT_LOCK;
            to_cnt_nxt = '0;
          end else begin
            rst_cnt_nxt = rst_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt   = ST_STABLE;
            stb_cnt_nxt = '0;
          end else if (to_cnt == TO_LAST) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = ST_FAIL;
            end else begin
              retry_nxt   = retry_cnt + 1'b1;
              state_nxt   = ST_RST_PLL;
              rst_cnt_nxt = '0;
            end
          end else begin
            to_cnt_nxt = to_cnt + 1'b1;
          end
        end
        ST_STABLE: begin
          // a lock drop on the terminal count still sends us back
          if (!lock_s) begin
            state_nxt  = ST_WAIT_LOCK;
            to_cnt_nxt = '0;
          end else if (stb_cnt == STB_LAST) begin
            state_nxt = ST_RUN;
            retry_nxt = '0;
          end else begin
            stb_cnt_nxt = stb_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt   = ST_RST_PLL;
            rst_cnt_nxt = '0;
            if (lost_cnt != 8'hFF) lost_nxt = lost_cnt + 1'b1;
          end
        end
        ST_FAIL: ;
        default: begin
          state_nxt   = ST_RST_PLL;
          rst_cnt_nxt = '0;
        end
      endcase
    end
  end

  // outputs are decoded from the next state so they switch with the state
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state     <= ST_RST_PLL;
      rst_cnt   <= '0;
      to_cnt    <= '0;
      stb_cnt   <= '0;
      retry_cnt <= '0;
      lost_cnt  <= '0;
      pll_reset <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rst_cnt   <= rst_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      stb_cnt   <= stb_cnt_nxt;
      retry_cnt <= retry_nxt;
      lost_cnt  <= lost_nxt;
      pll_reset <= (state_nxt == ST_RST_PLL) || (state_nxt == ST_FAIL);
      sys_reset <= (state_nxt != ST_RUN);
      ready     <= (state_nxt == ST_RUN);
      fail      <= (state_nxt == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=8, MAX_RETRY=2; expected cycle numbers are worked out by hand.
module tb_pll_lock_ctrl;

  logic       clkin   = 1'b0;
  logic       reset   = 1'b0;
  logic       lock    = 1'b0;
  logic       restart = 1'b0;
  logic       pll_reset, sys_reset, ready, fail;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  int err_cnt = 0;
  int chk_cnt = 0;

  pll_lock_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRY    (2)
  ) u_dut (
    .clkin    (clkin),
    .reset    (reset),
    .lock     (lock),
    .restart  (restart),
    .pll_reset(pll_reset),
    .sys_reset(sys_reset),
    .ready    (ready),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .lost_cnt (lost_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // advance n rising edges, then settle 1 time unit past the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // assert reset between edges, check outputs before any clock edge, then release
  task automatic do_reset(input logic lv);
    lock    = lv;
    restart = 1'b0;
    reset   = 1'b1;
    #2;
    check_val("rst.pll_reset", 32'(pll_reset), 32'd1);
    check_val("rst.sys_reset", 32'(sys_reset), 32'd1);
    check_val("rst.ready",     32'(ready),     32'd0);
    check_val("rst.fail",      32'(fail),      32'd0);
    check_val("rst.retry_cnt", 32'(retry_cnt), 32'd0);
    check_val("rst.lost_cnt",  32'(lost_cnt),  32'd0);
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    logic exp_pll;
    #1;

    // lock high throughout: pulse E1..E3, WAIT at E4, STABLE at E5, RUN at E13
    do_reset(1'b1);
    tick(3);
    check_val("clean.pll_hi_e3", 32'(pll_reset), 32'd1);
    tick(1);
    check_val("clean.pll_lo_e4", 32'(pll_reset), 32'd0);
    check_val("clean.sys_e4",    32'(sys_reset), 32'd1);
    tick(8);
    check_val("clean.ready_e12", 32'(ready), 32'd0);
    tick(1);
    check_val("clean.ready_e13", 32'(ready),     32'd1);
    check_val("clean.sys_e13",   32'(sys_reset), 32'd0);
    check_val("clean.retry_e13", 32'(retry_cnt), 32'd0);

    // glitch seen by the FSM at stable count 5 (E11): RUN delayed to E20
    do_reset(1'b1);
    tick(8);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    tick(4);
    check_val("glitch5.ready_e13", 32'(ready), 32'd0);
    tick(6);
    check_val("glitch5.ready_e19", 32'(ready), 32'd0);
    tick(1);
    check_val("glitch5.ready_e20", 32'(ready),     32'd1);
    check_val("glitch5.sys_e20",   32'(sys_reset), 32'd0);

    // glitch on the terminal stable count (E13): drop wins, RUN at E22
    do_reset(1'b1);
    tick(10);
    lock = 1'b0;
    tick(1);
    lock = 1'b1;
    tick(2);
    check_val("glitch7.ready_e13", 32'(ready), 32'd0);
    tick(8);
    check_val("glitch7.ready_e21", 32'(ready), 32'd0);
    tick(1);
    check_val("glitch7.ready_e22", 32'(ready), 32'd1);

    // lock loss in RUN: seen at D3, pulse D3..D6, RUN again at D16
    lock = 1'b0;
    tick(2);
    check_val("loss.ready_d2", 32'(ready),    32'd1);
    check_val("loss.lost_d2",  32'(lost_cnt), 32'd0);
    tick(1);
    check_val("loss.lost_d3",  32'(lost_cnt),  32'd1);
    check_val("loss.ready_d3", 32'(ready),     32'd0);
    check_val("loss.sys_d3",   32'(sys_reset), 32'd1);
    check_val("loss.pll_d3",   32'(pll_reset), 32'd1);
    lock = 1'b1;
    tick(3);
    check_val("loss.pll_d6", 32'(pll_reset), 32'd1);
    tick(1);
    check_val("loss.pll_d7", 32'(pll_reset), 32'd0);
    tick(8);
    check_val("loss.ready_d15", 32'(ready), 32'd0);
    tick(1);
    check_val("loss.ready_d16", 32'(ready),     32'd1);
    check_val("loss.lost_d16",  32'(lost_cnt),  32'd1);
    check_val("loss.retry_d16", 32'(retry_cnt), 32'd0);

    // drive lost_cnt up to 255, then one more loss must hold it there
    for (int i = 0; i < 254; i++) begin
      lock = 1'b0;
      tick(3);
      lock = 1'b1;
      tick(13);
    end
    check_val("sat.lost_255",  32'(lost_cnt), 32'd255);
    check_val("sat.ready_run", 32'(ready),    32'd1);
    lock = 1'b0;
    tick(3);
    check_val("sat.lost_hold", 32'(lost_cnt), 32'd255);
    check_val("sat.ready_off", 32'(ready),    32'd0);
    lock = 1'b1;
    tick(13);
    check_val("sat.ready_back", 32'(ready), 32'd1);

    // async reset from RUN (checked before any edge), then lock never comes
    do_reset(1'b0);
    for (int i = 1; i <= 72; i++) begin
      tick(1);
      exp_pll = (i < 4) || (i >= 24 && i < 28) || (i >= 48 && i < 52) || (i >= 72);
      check_val($sformatf("nolock.pll_e%0d", i), 32'(pll_reset), 32'(exp_pll));
      if (i == 23) check_val("nolock.retry_e23", 32'(retry_cnt), 32'd0);
      if (i == 24) check_val("nolock.retry_e24", 32'(retry_cnt), 32'd1);
      if (i == 47) check_val("nolock.retry_e47", 32'(retry_cnt), 32'd1);
      if (i == 48) check_val("nolock.retry_e48", 32'(retry_cnt), 32'd2);
      if (i == 71) check_val("nolock.fail_e71",  32'(fail),      32'd0);
      if (i == 72) begin
        check_val("nolock.fail_e72",  32'(fail),      32'd1);
        check_val("nolock.sys_e72",   32'(sys_reset), 32'd1);
        check_val("nolock.ready_e72", 32'(ready),     32'd0);
      end
    end
    tick(5);
    check_val("hold.fail",  32'(fail),      32'd1);
    check_val("hold.pll",   32'(pll_reset), 32'd1);
    check_val("hold.retry", 32'(retry_cnt), 32'd2);

    // restart out of the terminal state: fresh 4-cycle pulse R0..R3
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check_val("restart.fail_r0",  32'(fail),      32'd0);
    check_val("restart.retry_r0", 32'(retry_cnt), 32'd0);
    check_val("restart.pll_r0",   32'(pll_reset), 32'd1);
    tick(3);
    check_val("restart.pll_r3", 32'(pll_reset), 32'd1);
    tick(1);
    check_val("restart.pll_r4", 32'(pll_reset), 32'd0);
    check_val("restart.sys_r4", 32'(sys_reset), 32'd1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
